// File: rtl/pmp_csr_regs.sv
// pmp_csr_regs: PMP cfg/addr CSR file (WARL, granularity, lock) driving registered pmpcfg0/pmpcfg2/pmpaddr (54b per entry, flat) plus csr_rdata/rvalid/err and pmp_upd pulses
module pmp_csr_regs #(
  parameter int pmp_entries = 16,
  parameter int pmp_g = 10,
  parameter bit pmp_no_tor = 1'b0
) (
  input  logic                        clk300p,
  input  logic                        rstn,
  input  logic [1:0]                  prv,
  input  logic                        csr_we,
  input  logic                        csr_re,
  input  logic [11:0]                 csr_addr,
  input  logic [63:0]                 csr_wdata,
  output logic [63:0]                 csr_rdata,
  output logic                        csr_rvalid,
  output logic                        csr_err,
  output logic [63:0]                 pmpcfg0,
  output logic [63:0]                 pmpcfg2,
  output logic [pmp_entries*54-1:0]   pmpaddr,
  output logic                        pmp_upd
);
  localparam int iw = $clog2(pmp_entries);
  localparam logic [53:0] off_mask = pmp_g >= 1 ? (54'd1 << pmp_g) - 54'd1 : '0;
  localparam logic [53:0] napot_mask = pmp_g >= 2 ? (54'd1 << (pmp_g - 1)) - 54'd1 : '0;
  logic [pmp_entries-1:0][7:0] cfg_q, cfg_d;
  logic [pmp_entries-1:0][53:0] addr_q, addr_d, eff_q, eff_d;
  logic [pmp_entries-1:0] tor_lk;
  logic legal, wr;
  logic [63:0] rd;
  function automatic logic [7:0] cfg_legal(input logic [7:0] o, input logic [7:0] w);
    logic [1:0] a;
    a = ((w[4:3] == 2'b10 && pmp_g > 0) || (w[4:3] == 2'b01 && pmp_no_tor)) ? o[4:3] : w[4:3];
    return o[7] ? o : {w[7], 2'b00, a, w[2], w[1] & w[0], w[0]};
  endfunction
  function automatic logic [53:0] eff(input logic [53:0] r, input logic [1:0] a);
    return a == 2'b11 ? (r | napot_mask) : a == 2'b10 ? r : (r & ~off_mask);
  endfunction
  assign pmpcfg0 = cfg_q[7:0];
  if (pmp_entries > 8) begin : g_cfg2
    assign pmpcfg2 = cfg_q[pmp_entries-1:8];
  end else begin : g_no_cfg2
    assign pmpcfg2 = '0;
  end
  assign pmpaddr = eff_q;
  always_comb begin
    legal = prv == 2'b11 && (csr_addr == 12'h3A0 || (csr_addr == 12'h3A2 && pmp_entries > 8) ||
            (csr_addr[11:4] == 8'h3B && int'(csr_addr[3:0]) < pmp_entries));
    wr = csr_we && legal;
    rd = csr_addr == 12'h3A0 ? pmpcfg0 : csr_addr == 12'h3A2 ? pmpcfg2 : {10'b0, eff_q[csr_addr[iw-1:0]]};
  end
  always_comb begin
    cfg_d = cfg_q;
    addr_d = addr_q;
    eff_d = '0;
    tor_lk = '0;
    for (int i = 0; i < pmp_entries - 1; i++) tor_lk[i] = cfg_q[i+1][7] && cfg_q[i+1][4:3] == 2'b01;
    for (int i = 0; i < pmp_entries; i++) begin
      if (wr && ((csr_addr == 12'h3A0 && i < 8) || (csr_addr == 12'h3A2 && i >= 8)))
        cfg_d[i] = cfg_legal(cfg_q[i], csr_wdata[(i % 8) * 8 +: 8]);
      if (wr && csr_addr[11:4] == 8'h3B && int'(csr_addr[3:0]) == i && !cfg_q[i][7] && !tor_lk[i])
        addr_d[i] = csr_wdata[53:0];
      eff_d[i] = eff(addr_d[i], cfg_d[i][4:3]);
    end
  end
  always_ff @(posedge clk300p or negedge rstn) begin
    if (!rstn) begin
      cfg_q <= '0;
      addr_q <= '0;
      eff_q <= '0;
      pmp_upd <= 1'b0;
      csr_rvalid <= 1'b0;
      csr_err <= 1'b0;
      csr_rdata <= '0;
    end else begin
      cfg_q <= cfg_d;
      addr_q <= addr_d;
      eff_q <= eff_d;
      pmp_upd <= cfg_d != cfg_q || eff_d != eff_q;
      csr_rvalid <= csr_re;
      csr_err <= (csr_we || csr_re) && !legal;
      csr_rdata <= (csr_re && legal) ? rd : '0;
    end
  end
endmodule
